router_port_arbiter: RTL
========================

Name: router_port_arbiter

Overview:
Sequential output-port scheduler for the lookahead router datapath. The combinational route function decides one of three output directions per packet; this block shares those NUM_OUT output ports between NUM_IN input requesters. It uses wormhole locking (head to tail), round-robin fairness per output, and a one-flit registered output slot per port with valid/ready handshakes on both sides.

Parameters:
NUM_IN, 4, number of input requesters (≥2)
NUM_OUT, 3, number of output ports (matches route-function outputs po0..po2)
DATA_W, 32, flit payload width
DEST_W, 2, destination index width; must satisfy 2^DEST_W ≥ NUM_OUT

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_IN  flit present per input
in_head  in  NUM_IN  flit is packet head
in_tail  in  NUM_IN  flit is packet tail (head&tail = single-flit packet)
in_dest  in  NUM_IN*DEST_W  destination output index, sampled on head flits only
in_data  in  NUM_IN*DATA_W  payload
in_ready  out  NUM_IN  flit accepted this cycle when in_valid&in_ready
out_valid  out  NUM_OUT  output slot holds a flit
out_tail  out  NUM_OUT  slot flit is a tail
out_data  out  NUM_OUT*DATA_W  slot payload
out_ready  in  NUM_OUT  downstream accepts slot flit
err_drop  out  1  one-cycle pulse: flit discarded (bad dest or orphan body flit)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, out_tail=0, out_data=0, err_drop=0, all outputs IDLE, all rr pointers=0, all locks cleared. in_ready is combinational and therefore 0 while no output is IDLE/free.
- Per output o: state IDLE or LOCKED, owner index, rr pointer.
- slot_free[o] = !out_valid[o] | out_ready[o]. Drain and fill occur in the same cycle, giving one flit/cycle/port.
- IDLE: candidates are inputs with in_valid & in_head & in_dest==o that own no lock. If slot_free, grant the first candidate at or after rr (wrapping mod NUM_IN). The granted flit is loaded into the slot next edge (latency 1 cycle in→out_valid).
  - Granted head with tail: stay IDLE, rr ← winner+1 mod NUM_IN.
  - Granted head without tail: → LOCKED, owner ← winner.
- LOCKED: only the owner is served, and in_head/in_dest are ignored. Transfer when in_valid[owner] & slot_free. Tail transfer → IDLE, rr ← owner+1 mod NUM_IN. No timeout; a stalled owner holds the port indefinitely.
- in_ready[i] is 1 when i is granted or is the owner with slot_free, or when the flit is to be dropped. It is never 1 for a losing candidate.
- Drop cases, each accepted immediately (in_ready=1, no slot load, err_drop=1 next cycle):
  - head with in_dest ≥ NUM_OUT;
  - non-head flit from an input owning no lock.
- If several drops occur in one cycle, a single err_drop pulse is raised.
- Each input is steered by at most one output per cycle, because the dest is unique and the lock is unique.
- Reset asserted mid-packet: all locks and slots clear asynchronously and in-flight slot flits are lost. Body flits arriving after reset deassertion are dropped as orphans.
- out_data/out_tail hold their value while out_valid & !out_ready.

Decomposition:
- Package router_arb_pkg holds:
  - NUM_IN/NUM_OUT/DATA_W/DEST_W defaults;
  - dest_t (logic [DEST_W-1:0]);
  - port_state_e {IDLE, LOCKED};
  - flit_t struct {head, tail, dest, data}.
- Sub-module rr_pick: NUM_IN-wide request vector + pointer → one-hot grant, combinational. Instantiated once per output.
- Top contains the per-output state registers, slot registers, and in_ready/drop logic.

Test Plan:
- Single-flit packet, input 0, dest 2, head=tail=1, out_ready=1 → in_ready[0]=1 same cycle; out_valid[2]=1 with data next cycle; rr[2]=1.
- Inputs 0,1,2 each send single-flit heads to dest 1 every cycle, out_ready=1 → grants in order 0,1,2,0,…; one flit/cycle on out 1.
- Input 3 sends 4-flit packet to out 0 while input 1 requests out 0 → input 1 in_ready=0 until input 3's tail accepted; input 1 granted on the following free cycle; no interleaving of flits on out 0.
- Backpressure: out_ready[1]=0 for 5 cycles with slot full → out_data stable, in_ready for dest-1 traffic=0; release → drain and refill in the same cycle.
- Head with in_dest=3 (NUM_OUT=3) and a body flit with no lock → both accepted, no out_valid change, err_drop=1 one cycle later.
- rst_n pulled low after 2 of 4 flits of a packet → out_valid=0 immediately; remaining 2 body flits after release are dropped with err_drop pulses; a new head is granted normally.

Source files
------------

// File: rtl/router_arb_pkg.sv
// ---------------------------------------------------------------------------
// router_arb_pkg
// Shared types and defaults for the router output-port arbiter.
//   DEFAULT_NUM_IN  : number of input requesters
//   DEFAULT_NUM_OUT : number of output ports (route-function outputs)
//   DEFAULT_DATA_W  : flit payload width
//   DEFAULT_DEST_W  : destination index width
//   dest_t          : destination index type
//   port_state_e    : per-output wormhole state
//   flit_t          : one flit as seen on an input
//   wrap_add        : modular index arithmetic used by the round-robin logic
// ---------------------------------------------------------------------------
package router_arb_pkg;

   localparam int DEFAULT_NUM_IN  = 4;
   localparam int DEFAULT_NUM_OUT = 3;
   localparam int DEFAULT_DATA_W  = 32;
   localparam int DEFAULT_DEST_W  = 2;

   typedef logic [DEFAULT_DEST_W-1:0] dest_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } port_state_e;

   typedef struct packed {
      logic                      head;
      logic                      tail;
      dest_t                     dest;
      logic [DEFAULT_DATA_W-1:0] data;
   } flit_t;

   // (base + off) mod n, for walking requester indices in a ring
   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/router_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping around the ring of N requesters.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority requester index
//   grant : one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module rr_pick
   import router_arb_pkg::*;
#(
   parameter int N     = DEFAULT_NUM_IN,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   // Walk the ring starting at ptr and keep only the first requester found
   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = wrap_add(int'(ptr), k, N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_port_arbiter.sv
// ---------------------------------------------------------------------------
// router_port_arbiter
// Shares NUM_OUT output ports between NUM_IN input requesters. Each output
// keeps a wormhole lock (head to tail), a round-robin pointer, and a one-flit
// registered slot with valid/ready handshaking on both sides. Heads with an
// out-of-range destination and body flits from inputs holding no lock are
// accepted and discarded, raising err_drop one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : flit present per input
//   in_head    : flit is a packet head
//   in_tail    : flit is a packet tail
//   in_dest    : destination output index per input (heads only)
//   in_data    : payload per input
//   in_ready   : flit accepted this cycle (combinational)
//   out_valid  : output slot holds a flit
//   out_tail   : slot flit is a tail
//   out_data   : slot payload
//   out_ready  : downstream accepts the slot flit
//   err_drop   : one-cycle pulse after any flit was discarded
// ---------------------------------------------------------------------------
module router_port_arbiter
   import router_arb_pkg::*;
#(
   parameter int NUM_IN  = DEFAULT_NUM_IN,
   parameter int NUM_OUT = DEFAULT_NUM_OUT,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int DEST_W  = DEFAULT_DEST_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_IN-1:0]         in_valid,
   input  logic [NUM_IN-1:0]         in_head,
   input  logic [NUM_IN-1:0]         in_tail,
   input  logic [NUM_IN*DEST_W-1:0]  in_dest,
   input  logic [NUM_IN*DATA_W-1:0]  in_data,
   output logic [NUM_IN-1:0]         in_ready,
   output logic [NUM_OUT-1:0]        out_valid,
   output logic [NUM_OUT-1:0]        out_tail,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   input  logic [NUM_OUT-1:0]        out_ready,
   output logic                      err_drop
);

   localparam int IDX_W = $clog2(NUM_IN);

   port_state_e        state    [NUM_OUT];
   logic [IDX_W-1:0]   owner    [NUM_OUT];
   logic [IDX_W-1:0]   rr       [NUM_OUT];
   logic [NUM_IN-1:0]  req      [NUM_OUT];
   logic [NUM_IN-1:0]  pick     [NUM_OUT];
   logic [IDX_W-1:0]   load_idx [NUM_OUT];
   logic [NUM_OUT-1:0] slot_free;
   logic [NUM_OUT-1:0] load;
   logic [NUM_IN-1:0]  locked_in;
   logic [NUM_IN-1:0]  drop;

   // A slot can take a new flit when empty or when its flit leaves this cycle
   always_comb begin
      slot_free = ~out_valid | out_ready;
   end

   // Inputs that currently own a wormhole lock on some output
   always_comb begin
      locked_in = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (state[o] == LOCKED && owner[o] == IDX_W'(i)) begin
               locked_in[i] = 1'b1;
            end
         end
      end
   end

   // Classify unlocked inputs: bad heads and orphan body flits are dropped,
   // well-formed heads become requests on their destination output. Lock
   // owners are steered only by their locked output, so head/dest are ignored.
   always_comb begin
      drop = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         req[o] = '0;
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (in_valid[i] && !locked_in[i]) begin
            if (!in_head[i] || int'(in_dest[i*DEST_W +: DEST_W]) >= NUM_OUT) begin
               drop[i] = 1'b1;
            end else begin
               for (int o = 0; o < NUM_OUT; o++) begin
                  if (in_dest[i*DEST_W +: DEST_W] == DEST_W'(o)) begin
                     req[o][i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   for (genvar o = 0; o < NUM_OUT; o++) begin : g_pick
      rr_pick #(
         .N (NUM_IN)
      ) u_pick (
         .req   (req[o]),
         .ptr   (rr[o]),
         .grant (pick[o])
      );
   end

   // Decide which input each output loads this cycle. A locked output serves
   // only its owner; an idle one takes the round-robin winner. Accepting a
   // flit (loaded or dropped) is what raises in_ready.
   always_comb begin
      load     = '0;
      in_ready = drop;
      for (int o = 0; o < NUM_OUT; o++) begin
         load_idx[o] = '0;
         if (state[o] == LOCKED) begin
            load_idx[o] = owner[o];
            load[o]     = slot_free[o] && in_valid[owner[o]];
         end else begin
            for (int i = 0; i < NUM_IN; i++) begin
               if (pick[o][i]) begin
                  load_idx[o] = IDX_W'(i);
               end
            end
            load[o] = slot_free[o] && (pick[o] != '0);
         end
         if (load[o]) begin
            in_ready[load_idx[o]] = 1'b1;
         end
      end
   end

   // Slot registers and wormhole state. A tail always releases the port and
   // moves priority past the input that just finished; a non-tail keeps or
   // takes the lock for that input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < NUM_OUT; o++) begin
            state[o] <= IDLE;
            owner[o] <= '0;
            rr[o]    <= '0;
         end
         out_valid <= '0;
         out_tail  <= '0;
         out_data  <= '0;
         err_drop  <= 1'b0;
      end else begin
         err_drop <= |drop;
         for (int o = 0; o < NUM_OUT; o++) begin
            if (load[o]) begin
               out_valid[o]                 <= 1'b1;
               out_tail[o]                  <= in_tail[load_idx[o]];
               out_data[o*DATA_W +: DATA_W] <= in_data[load_idx[o]*DATA_W +: DATA_W];
               if (in_tail[load_idx[o]]) begin
                  state[o] <= IDLE;
                  rr[o]    <= IDX_W'(wrap_add(int'(load_idx[o]), 1, NUM_IN));
               end else begin
                  state[o] <= LOCKED;
                  owner[o] <= load_idx[o];
               end
            end else if (out_ready[o]) begin
               out_valid[o] <= 1'b0;
            end
         end
      end
   end

endmodule
